// File: rtl/fifo_rblock_if.sv
// fifo_rblock_if: consumer-side output handshake of the FIFO read block.
// dout/dvalid flow to the consumer, dready flows back.
interface fifo_rblock_if;
  logic [7:0] dout;
  logic       dvalid;
  logic       dready;

  modport master (
    output dout,
    output dvalid,
    input  dready
  );

  modport slave (
    input  dout,
    input  dvalid,
    output dready
  );
endinterface

// File: rtl/fifo_rblock.sv
// fifo_rblock: read-side control of the async FIFO (rclk domain).
// Syncs the write pointer, tracks empty/count, feeds a 1-entry FWFT stage.
module fifo_rblock #(
  parameter int ADDR_W = 23
) (
  input  logic              rclk,
  input  logic              rrst,
  input  logic [ADDR_W:0]   wptr_gray,
  input  logic [7:0]        mem_rdata,
  output logic [ADDR_W-1:0] raddr,
  output logic [ADDR_W:0]   rptr_gray,
  output logic              rempty,
  output logic [ADDR_W:0]   rcount,
  fifo_rblock_if.master     rd
);

  localparam int PW = ADDR_W + 1;

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [PW-1:0] wq1_q, wq2_q;
  logic [PW-1:0] rbin_q, rbin_d;
  logic [PW-1:0] rgray_q, rgray_d;
  logic          rempty_q, rempty_d;
  logic [7:0]    dout_q, dout_d;
  logic          dvalid_q, dvalid_d;
  logic [PW-1:0] wbin_s;
  logic          pop;

  // Two-flop synchronizer for the Gray write pointer.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      wq1_q <= '0;
      wq2_q <= '0;
    end else begin
      wq1_q <= wptr_gray;
      wq2_q <= wq1_q;
    end
  end

  // Pop whenever memory has a word and the output slot is free or draining.
  always_comb begin
    pop      = ~rempty_q & (~dvalid_q | rd.dready);
    rbin_d   = rbin_q;
    dout_d   = dout_q;
    dvalid_d = dvalid_q;
    if (pop) begin
      rbin_d   = rbin_q + PW'(1);
      dout_d   = mem_rdata;
      dvalid_d = 1'b1;
    end else if (dvalid_q & rd.dready) begin
      dvalid_d = 1'b0;
    end
    rgray_d  = bin2gray(rbin_d);
    rempty_d = (rgray_d == wq2_q);
  end

  // Read pointer, empty flag and output stage registers.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin_q   <= '0;
      rgray_q  <= '0;
      rempty_q <= 1'b1;
      dout_q   <= 8'h00;
      dvalid_q <= 1'b0;
    end else begin
      rbin_q   <= rbin_d;
      rgray_q  <= rgray_d;
      rempty_q <= rempty_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
    end
  end

  // Occupancy as seen through the synchronizer; modulo pointer width.
  always_comb begin
    wbin_s = gray2bin(wq2_q);
    rcount = wbin_s - rbin_q;
  end

  assign raddr     = rbin_q[ADDR_W-1:0];
  assign rptr_gray = rgray_q;
  assign rempty    = rempty_q;
  assign rd.dout   = dout_q;
  assign rd.dvalid = dvalid_q;

endmodule
